timer_arbiter: RTL

Shares one down-counting interval timer between N_REQ requesters. Each requester raises `req` with a cycle count on its `len` lane. The block grants the timer to one requester at a time in round-robin order, runs the count, and pulses that requester's `done` bit when the count expires. It sits beside the clock-divider counter block and serves control logic that needs timed waits without each client owning its own counter.

---
 rtl/timer_arbiter_pkg.sv | 14 +
 rtl/timer_arbiter_rr_pick.sv | 35 +++
 rtl/timer_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/timer_arbiter_pkg.sv
// Shared types and limits for the timer arbiter.
// Combinational-only contents; no timing or flow control here.
// State encoding is fixed at 2 bits so debug views stay stable.
package timer_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int TIMER_ARB_MAX_REQ = 8;

endpackage

// File: rtl/timer_arbiter_rr_pick.sv
// Round-robin selector: first set req bit searching upward from ptr+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the pick.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] sel_oh,
    output logic [IDX_W-1:0] sel_idx,
    output logic             any
);

    always_comb begin
        int idx;
        idx     = 0;
        sel_oh  = '0;
        sel_idx = '0;
        any     = 1'b0;
        // k starts at 1 so the last winner is visited last.
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!any && req[IDX_W'(idx)]) begin
                sel_oh[IDX_W'(idx)] = 1'b1;
                sel_idx             = IDX_W'(idx);
                any                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// Shares one down-counting timer between N_REQ requesters, round-robin; optional TIMER_ARB_ABORT_EN adds abort.
// Latency: grant one edge after req seen in IDLE; done pulse L edges later; job period L+2 cycles.
// Backpressure: req is a level held by the client; changes during RUN/DONE are ignored.
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] len,
`ifdef TIMER_ARB_ABORT_EN
    input  logic                   abort,
`endif
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [CNT_W-1:0]       cnt
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   sel_q, sel_d;

    logic [N_REQ-1:0]   pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [CNT_W-1:0]   pick_len;
    logic [CNT_W-1:0]   load_val;
    logic               abort_hit;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .sel_oh  (pick_oh),
        .sel_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        pick_len = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_len = len[i*CNT_W +: CNT_W];
            end
        end
    end

    // A zero length still costs one cycle so the counter never wraps.
    assign load_val = (pick_len == '0) ? CNT_W'(1) : pick_len;

`ifdef TIMER_ARB_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = done_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = RUN;
                    grant_d = pick_oh;
                    cnt_d   = load_val;
                    sel_d   = pick_idx;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (abort_hit) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = sel_q;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    grant_d = '0;
                    cnt_d   = '0;
                    done_d  = grant_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = '0;
                busy_d  = 1'b0;
                ptr_d   = sel_q;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                done_d  = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= IDX_W'(N_REQ - 1);
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign cnt   = cnt_q;

endmodule
